// File: rtl/gpio_in_conditioner_if.sv
// Signal bundle between the GPIO pad-side controls and the input conditioner.
// The slave modport is the conditioner; the master modport is whatever drives and observes it.
interface gpio_in_conditioner_if #(
  parameter int WIDTH = 32,
  parameter int DB_W  = 8
);
  logic [WIDTH-1:0] pad_in;
  logic [WIDTH-1:0] db_en;
  logic [DB_W-1:0]  db_limit;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] irq_clr;
  logic [WIDTH-1:0] pin_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] irq_pending;
  logic             irq;

  modport master (
    output pad_in, db_en, db_limit, irq_mask, irq_clr,
    input  pin_out, rise, fall, irq_pending, irq
  );

  modport slave (
    input  pad_in, db_en, db_limit, irq_mask, irq_clr,
    output pin_out, rise, fall, irq_pending, irq
  );
endinterface

// File: rtl/gpio_in_conditioner.sv
// Per-bit pad synchroniser, optional debounce filter, edge strobes and sticky
// maskable edge-pending flags, all in the ext_clk domain.
module gpio_in_conditioner #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 8
) (
  input  logic                  ext_clk,
  input  logic                  ext_rst,
  gpio_in_conditioner_if.slave  bus
);

  logic [WIDTH-1:0] stable_reg;
  logic [WIDTH-1:0] stable_next;
  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] fall_reg;
  logic [WIDTH-1:0] pending_reg;
  logic [WIDTH-1:0] pending_next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      // SYNC_STAGES must be at least 2; the shift below relies on it.
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [DB_W-1:0]        cnt_reg;
      logic [DB_W-1:0]        cnt_next;
      logic                   s;
      logic                   bit_next;

      assign s = sync_reg[SYNC_STAGES-1];

      always_ff @(posedge ext_clk) begin
        if (ext_rst) begin
          sync_reg <= '0;
          cnt_reg  <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.pad_in[gi]};
          cnt_reg  <= cnt_next;
        end
      end

      // The count only increments while below the limit, so it can never wrap;
      // a limit of 0 makes debounce update on the first mismatch, same as bypass.
      always_comb begin
        cnt_next = '0;
        bit_next = stable_reg[gi];
        if (!bus.db_en[gi]) begin
          bit_next = s;
        end else if (s != stable_reg[gi]) begin
          if (cnt_reg >= bus.db_limit) begin
            bit_next = s;
          end else begin
            cnt_next = cnt_reg + DB_W'(1);
          end
        end
      end

      assign stable_next[gi] = bit_next;
    end
  endgenerate

  // Pending set wins over a clear arriving on the same edge.
  assign pending_next = (pending_reg & ~bus.irq_clr)
                      | ((rise_reg | fall_reg) & ~bus.irq_mask);

  always_ff @(posedge ext_clk) begin
    if (ext_rst) begin
      stable_reg  <= '0;
      rise_reg    <= '0;
      fall_reg    <= '0;
      pending_reg <= '0;
    end else begin
      stable_reg  <= stable_next;
      rise_reg    <= stable_next & ~stable_reg;
      fall_reg    <= ~stable_next & stable_reg;
      pending_reg <= pending_next;
    end
  end

  assign bus.pin_out     = stable_reg;
  assign bus.rise        = rise_reg;
  assign bus.fall        = fall_reg;
  assign bus.irq_pending = pending_reg;
  assign bus.irq         = |pending_reg;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed checks of the GPIO input conditioner: reset, bypass latency,
// debounce filtering, mask/clear, set-vs-clear priority and reset mid-count.
module tb_gpio_in_conditioner;
  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] acc;

  gpio_in_conditioner_if #(.WIDTH(32), .DB_W(8)) bus ();

  gpio_in_conditioner #(
    .WIDTH(32),
    .SYNC_STAGES(2),
    .DB_W(8)
  ) dut (
    .ext_clk(clk),
    .ext_rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok %s: %h", tag, got);
    end
  endtask

  task automatic clear_all();
    bus.irq_clr = 32'hFFFF_FFFF;
    tick(1);
    bus.irq_clr = 32'h0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.pad_in   = 32'hFFFF_FFFF;
    bus.db_en    = 32'h0;
    bus.db_limit = 8'd0;
    bus.irq_mask = 32'h0;
    bus.irq_clr  = 32'h0;

    // Reset values
    tick(3);
    chk("rst_pin", bus.pin_out, 32'h0);
    chk("rst_rise", bus.rise, 32'h0);
    chk("rst_fall", bus.fall, 32'h0);
    chk("rst_pend", bus.irq_pending, 32'h0);
    chk("rst_irq", {31'h0, bus.irq}, 32'h0);
    rst = 1'b0;
    tick(2);
    chk("post_rst_pin_early", bus.pin_out, 32'h0);
    tick(1);
    chk("post_rst_pin", bus.pin_out, 32'hFFFF_FFFF);
    chk("post_rst_rise", bus.rise, 32'hFFFF_FFFF);
    chk("post_rst_fall", bus.fall, 32'h0);
    tick(1);
    chk("post_rst_rise_off", bus.rise, 32'h0);
    chk("post_rst_pend", bus.irq_pending, 32'hFFFF_FFFF);
    chk("post_rst_irq", {31'h0, bus.irq}, 32'h1);
    clear_all();
    chk("clr_all_pend", bus.irq_pending, 32'h0);
    chk("clr_all_irq", {31'h0, bus.irq}, 32'h0);

    // Bypass latency on bit 5
    bus.pad_in = 32'h0;
    tick(4);
    clear_all();
    chk("settle_low_pend", bus.irq_pending, 32'h0);
    bus.pad_in = 32'h20;
    tick(2);
    chk("byp_pin_early", bus.pin_out, 32'h0);
    tick(1);
    chk("byp_pin", bus.pin_out, 32'h20);
    chk("byp_rise", bus.rise, 32'h20);
    tick(1);
    chk("byp_rise_off", bus.rise, 32'h0);
    chk("byp_pend", bus.irq_pending, 32'h20);

    // Debounce on bit 0, limit 4
    clear_all();
    bus.db_en    = 32'h1;
    bus.db_limit = 8'd4;
    acc = 32'h0;
    for (int n = 0; n < 12; n++) begin
      bus.pad_in = (n < 3) ? 32'h21 : 32'h20;
      tick(1);
      acc = acc | ((bus.pin_out | bus.rise) & 32'h1);
    end
    chk("db_pulse_filtered", acc, 32'h0);
    bus.pad_in = 32'h21;
    tick(6);
    chk("db_step_pin_early", bus.pin_out & 32'h1, 32'h0);
    tick(1);
    chk("db_step_pin", bus.pin_out & 32'h1, 32'h1);
    chk("db_step_rise", bus.rise, 32'h1);
    for (int n = 1; n <= 12; n++) begin
      bus.pad_in = (n == 5) ? 32'h21 : 32'h20;
      tick(1);
      if (n == 7)  chk("db_glitch_hold7", bus.pin_out & 32'h1, 32'h1);
      if (n == 11) chk("db_glitch_hold11", bus.pin_out & 32'h1, 32'h1);
      if (n == 12) begin
        chk("db_glitch_pin", bus.pin_out & 32'h1, 32'h0);
        chk("db_glitch_fall", bus.fall, 32'h1);
      end
    end

    // Mask and clear on bit 3
    bus.db_en    = 32'h0;
    bus.db_limit = 8'd0;
    tick(2);
    clear_all();
    bus.irq_mask = 32'h8;
    bus.pad_in   = 32'h28;
    tick(5);
    chk("mask_pin", bus.pin_out, 32'h28);
    chk("mask_pend", bus.irq_pending, 32'h0);
    bus.irq_mask = 32'h0;
    bus.pad_in   = 32'h20;
    tick(3);
    chk("unmask_fall", bus.fall, 32'h8);
    tick(1);
    chk("unmask_pend", bus.irq_pending, 32'h8);
    chk("unmask_irq", {31'h0, bus.irq}, 32'h1);
    bus.irq_mask = 32'h8;
    tick(1);
    chk("mask_keeps_pend", bus.irq_pending, 32'h8);
    bus.irq_clr = 32'h8;
    tick(1);
    bus.irq_clr = 32'h0;
    chk("clr3_pend", bus.irq_pending, 32'h0);
    chk("clr3_irq", {31'h0, bus.irq}, 32'h0);
    bus.irq_mask = 32'h0;

    // Set beats clear on bit 7
    bus.pad_in = 32'hA0;
    tick(4);
    chk("b7_rise_pend", bus.irq_pending, 32'h80);
    bus.pad_in = 32'h20;
    tick(3);
    chk("b7_fall", bus.fall, 32'h80);
    bus.irq_clr = 32'h80;
    tick(1);
    bus.irq_clr = 32'h0;
    chk("set_beats_clr", bus.irq_pending, 32'h80);
    bus.irq_clr = 32'h80;
    tick(1);
    bus.irq_clr = 32'h0;
    chk("b7_cleared", bus.irq_pending, 32'h0);

    // Reset mid-count on bit 2, limit 10
    bus.db_en    = 32'h4;
    bus.db_limit = 8'd10;
    bus.pad_in   = 32'h24;
    tick(8);
    chk("rmc_pin_before", bus.pin_out & 32'h4, 32'h0);
    rst = 1'b1;
    tick(2);
    chk("rmc_rst_pin", bus.pin_out, 32'h0);
    rst = 1'b0;
    acc = 32'h0;
    for (int n = 0; n < 12; n++) begin
      tick(1);
      acc = acc | ((bus.rise | bus.fall) & 32'h4);
    end
    chk("rmc_no_stale_edge", acc, 32'h0);
    chk("rmc_pin_early", bus.pin_out & 32'h4, 32'h0);
    tick(1);
    chk("rmc_pin", bus.pin_out & 32'h4, 32'h4);
    chk("rmc_rise", bus.rise & 32'h4, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gpio_in_conditioner.md
# gpio_in_conditioner

Input conditioning stage between the openframe GPIO input pads and the Microwatt core's `gpio_in` bus. It synchronises each asynchronous pad input into the `ext_clk` domain and applies an optional per-bit debounce filter. It produces the conditioned level for the core, plus per-bit rise/fall strobes and a maskable sticky edge-pending interrupt. All state is in the core clock domain.

## Interface
- `WIDTH`, default 32: number of conditioned GPIO bits.
- `SYNC_STAGES`, default 2: synchroniser depth per bit, minimum 2.
- `DB_W`, default 8: width of the per-bit debounce counter and the threshold.

- `ext_clk`  in  1: core clock; the single clock of this block.
- `ext_rst`  in  1: synchronous, active-high reset, sampled on the `ext_clk` rising edge.
- `pad_in`  in  WIDTH: raw asynchronous pad inputs.
- `db_en`  in  WIDTH: per-bit debounce enable; 0 selects bypass.
- `db_limit`  in  DB_W: debounce threshold, shared by all bits; quasi-static.
- `irq_mask`  in  WIDTH: 1 blocks the bit from setting pending.
- `irq_clr`  in  WIDTH: 1-cycle write-one-to-clear strobe for pending bits.
- `pin_out`  out  WIDTH: conditioned level, drives the core `gpio_in`.
- `rise`  out  WIDTH: 1-cycle strobe when `pin_out[i]` goes 0→1.
- `fall`  out  WIDTH: 1-cycle strobe when `pin_out[i]` goes 1→0.
- `irq_pending`  out  WIDTH: sticky edge flags.
- `irq`  out  1: OR-reduction of `irq_pending`.

## Operation
- **Synchroniser.** Bit i passes through a `SYNC_STAGES`-deep flop chain; the last stage is `s[i]`.
- **Stable register.** `stable[i]` holds the level presented as `pin_out[i]`.
- **Bypass (`db_en[i]`=0):**
  - `stable[i] <= s[i]` every cycle.
  - `cnt[i]` is forced to 0.
- **Debounce (`db_en[i]`=1):**
  - `s[i]` == `stable[i]`: `cnt[i] <= 0`.
  - `s[i]` != `stable[i]` and `cnt[i]` < `db_limit`: `cnt[i] <= cnt[i]+1`. Any glitch back to `stable[i]` restarts the count from 0.
  - `s[i]` != `stable[i]` and `cnt[i]` >= `db_limit`: `stable[i] <= s[i]` and `cnt[i] <= 0`.
  - `db_limit`=0 behaves identically to bypass.
  - Lowering `db_limit` below a running count causes the update on the next edge, because the comparison is >=.
  - The counter saturates by construction and never wraps.
- **Edge strobes.**
  - `rise[i]` and `fall[i]` are registered and assert on the same edge that `pin_out[i]` changes.
  - Each strobe is high for exactly one cycle.
  - `rise[i]` and `fall[i]` are never high together.
- **Pending flags.**
  - Set term: `(rise[i] | fall[i]) & ~irq_mask[i]`.
  - `irq_pending[i]` is updated one edge after the strobe.
  - Set has priority over a simultaneous `irq_clr[i]`.
  - Masking a bit does not clear an already-set pending flag.
- **`irq`** is combinational OR of `irq_pending`, with no extra register.
- **Reset.**
  - All sync flops, `stable`, `cnt`, `rise`, `fall` and `irq_pending` go to 0, so `pin_out`=0 and `irq`=0.
  - If a pad is held high through reset, a `rise` is generated once it propagates after reset deasserts. Software clears it.
  - Reset mid-count discards the count.

## Timing
- **Bypass latency:** a pad change sampled at edge E0 appears on `pin_out` at edge E0+`SYNC_STAGES`, i.e. `SYNC_STAGES`+1 flops including `stable`.
- **Debounce latency:** a clean step appears on `pin_out` `db_limit` cycles later than in bypass.
- **Pending:** `irq_pending` and `irq` rise one cycle after the `rise`/`fall` strobe.
- **Clear:** `irq_clr` takes effect on the edge on which it is sampled.
- **Pulse filtering:** a pad pulse shorter than `db_limit`+1 synchronised cycles never reaches `pin_out` in debounce mode.
- **Throughput:** the block has no back-pressure and processes every cycle.

## Test plan
1. **Reset values.** Drive `ext_rst`=1 for 3 cycles with `pad_in`=0xFFFF_FFFF and `db_en`=0, then release.
   - During reset: all outputs are 0.
   - Then `pin_out` becomes 0xFFFF_FFFF and `rise`=0xFFFF_FFFF for one cycle.
   - Then `irq_pending`=0xFFFF_FFFF and `irq`=1.
2. **Bypass latency.** Set `SYNC_STAGES`=2 and `db_en`=0, then step `pad_in[5]` 0→1.
   - `pin_out[5]` goes high 2 edges after the sampling edge.
   - `rise[5]` pulses for one cycle coincident with it.
3. **Debounce filtering.** Set `db_en[0]`=1 and `db_limit`=4.
   - Drive a 3-cycle high pulse: `pin_out[0]` and `rise[0]` stay 0.
   - Then drive a sustained high: `pin_out[0]` goes high 4 cycles later than the bypass timing.
   - Then toggle a glitch mid-count: the count restarts and the transition is delayed accordingly.
4. **Mask and clear.** Set `irq_mask[3]`=1 and toggle pad 3: `irq_pending[3]` stays 0.
   - Unmask and toggle: `irq_pending[3]`=1.
   - Pulse `irq_clr[3]`: the flag is 0 on the next cycle.
5. **Set beats clear.** Assert `irq_clr[7]` in the same cycle that `fall[7]` pulses: `irq_pending[7]` is 1 afterwards.
6. **Reset mid-count.** Set `db_limit`=10, drive a step on pad 2, and assert `ext_rst` at count 6.
   - After release, `pin_out[2]` needs the full latency again.
   - No stale `rise` or `fall` is produced.
